// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, phase FSMs
// and registered sync/blank/coordinate outputs that all describe the same pixel.
module vga_timing_gen #(
   parameter int CW      = 11,
   parameter int HACTIVE = 640,
   parameter int HFP     = 16,
   parameter int HSYN    = 96,
   parameter int HBP     = 48,
   parameter int VACTIVE = 480,
   parameter int VFP     = 10,
   parameter int VSYN    = 2,
   parameter int VBP     = 33,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int CLKDIV  = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   output logic          o_pix_ce,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_blank_n,
   output logic          o_sync_n,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_sol,
   output logic          o_sof
);

   localparam int HTOT = HSYN + HBP + HACTIVE + HFP;
   localparam int HSS  = HSYN + HBP;
   localparam int HSE  = HSS + HACTIVE;
   localparam int VTOT = VSYN + VBP + VACTIVE + VFP;
   localparam int VSS  = VSYN + VBP;
   localparam int VSE  = VSS + VACTIVE;
   localparam int DW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam longint CMAX = (longint'(1) << CW) - 1;

   if (longint'(HTOT - 1) > CMAX || longint'(VTOT - 1) > CMAX) begin : g_cw_too_small
      $error("vga_timing_gen: CW too small for HTOT/VTOT");
   end
   if (CLKDIV < 1) begin : g_bad_clkdiv
      $error("vga_timing_gen: CLKDIV must be >= 1");
   end

   localparam logic [CW-1:0] H_LAST    = CW'(HTOT - 1);
   localparam logic [CW-1:0] HSYN_LAST = CW'(HSYN - 1);
   localparam logic [CW-1:0] HSS_LAST  = CW'(HSS - 1);
   localparam logic [CW-1:0] HSE_LAST  = CW'(HSE - 1);
   localparam logic [CW-1:0] HSS_C     = CW'(HSS);
   localparam logic [CW-1:0] V_LAST    = CW'(VTOT - 1);
   localparam logic [CW-1:0] VSYN_LAST = CW'(VSYN - 1);
   localparam logic [CW-1:0] VSS_LAST  = CW'(VSS - 1);
   localparam logic [CW-1:0] VSE_LAST  = CW'(VSE - 1);
   localparam logic [CW-1:0] VSS_C     = CW'(VSS);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);

   typedef enum logic [1:0] {SYNC, BP, ACTIVE, FP} phase_t;

   logic [DW-1:0] div_q, div_nxt;
   logic [CW-1:0] hcnt, vcnt, h_nxt, v_nxt;
   logic          tick, h_wrap, v_wrap;
   phase_t        hst, hst_nxt, vst, vst_nxt;

   // Next counter values; everything visible is decoded from these so that
   // the registered outputs line up with the registered counters.
   always_comb begin
      tick    = i_en && (div_q == DIV_LAST);
      div_nxt = div_q;
      if (i_en) div_nxt = tick ? '0 : div_q + DW'(1);
      h_wrap = tick && (hcnt == H_LAST);
      v_wrap = h_wrap && (vcnt == V_LAST);
      h_nxt  = hcnt;
      if (tick) h_nxt = h_wrap ? '0 : hcnt + CW'(1);
      v_nxt  = vcnt;
      if (h_wrap) v_nxt = v_wrap ? '0 : vcnt + CW'(1);
   end

   always_comb begin
      hst_nxt = hst;
      if (tick) begin
         case (hst)
            SYNC:    if (hcnt == HSYN_LAST) hst_nxt = BP;
            BP:      if (hcnt == HSS_LAST)  hst_nxt = ACTIVE;
            ACTIVE:  if (hcnt == HSE_LAST)  hst_nxt = FP;
            FP:      if (h_wrap)            hst_nxt = SYNC;
            default: hst_nxt = SYNC;
         endcase
      end
   end

   always_comb begin
      vst_nxt = vst;
      if (h_wrap) begin
         case (vst)
            SYNC:    if (vcnt == VSYN_LAST) vst_nxt = BP;
            BP:      if (vcnt == VSS_LAST)  vst_nxt = ACTIVE;
            ACTIVE:  if (vcnt == VSE_LAST)  vst_nxt = FP;
            FP:      if (v_wrap)            vst_nxt = SYNC;
            default: vst_nxt = SYNC;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hst <= SYNC;
         vst <= SYNC;
      end else begin
         hst <= hst_nxt;
         vst <= vst_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q     <= '0;
         hcnt      <= '0;
         vcnt      <= '0;
         o_pix_ce  <= 1'b0;
         o_sol     <= 1'b0;
         o_sof     <= 1'b0;
         o_hs      <= HS_POL;
         o_vs      <= VS_POL;
         o_blank_n <= 1'b0;
         o_x       <= '0;
         o_y       <= '0;
      end else begin
         div_q     <= div_nxt;
         hcnt      <= h_nxt;
         vcnt      <= v_nxt;
         o_pix_ce  <= tick;
         o_sol     <= tick && (h_nxt == '0);
         o_sof     <= tick && (h_nxt == '0) && (v_nxt == '0);
         o_hs      <= (hst_nxt == SYNC) ? HS_POL : ~HS_POL;
         o_vs      <= (vst_nxt == SYNC) ? VS_POL : ~VS_POL;
         o_blank_n <= (hst_nxt == ACTIVE) && (vst_nxt == ACTIVE);
         o_x       <= (hst_nxt == ACTIVE) ? h_nxt - HSS_C : '0;
         o_y       <= (vst_nxt == ACTIVE) ? v_nxt - VSS_C : '0;
      end
   end

   assign o_sync_n = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (CLKDIV=2 active-low
// syncs, CLKDIV=1 active-high syncs) against a per-cycle scoreboard model.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 2, HSY = 3, HB = 4;
   localparam int VA = 6,  VF = 1, VSY = 2, VB = 3;
   localparam int HTOT_T = HSY + HB + HA + HF;
   localparam int HSS_T  = HSY + HB;
   localparam int HSE_T  = HSS_T + HA;
   localparam int VTOT_T = VSY + VB + VA + VF;
   localparam int VSS_T  = VSY + VB;
   localparam int VSE_T  = VSS_T + VA;
   localparam int VW     = 7 + 2 * 11;

   localparam int S_APCE = 0, S_AHS = 1, S_AVS = 2, S_ABLK = 3, S_ASOL = 4, S_ASOF = 5;
   localparam int S_BHS = 6, S_BVS = 7, S_BBLK = 8, S_BSOL = 9, S_BSOF = 10;

   logic clk = 1'b0;
   logic rst_n, en;
   logic a_pix_ce, a_hs, a_vs, a_blank_n, a_sync_n, a_sol, a_sof;
   logic b_pix_ce, b_hs, b_vs, b_blank_n, b_sync_n, b_sol, b_sof;
   logic [10:0] a_x, a_y, b_x, b_y;
   logic [VW-1:0] act0, act1;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int m_div[2], m_h[2], m_v[2];
   logic [VW-1:0] q0[$];
   logic [VW-1:0] q1[$];

   always #5 clk = ~clk;

   vga_timing_gen #(.CW(11), .HACTIVE(HA), .HFP(HF), .HSYN(HSY), .HBP(HB),
                    .VACTIVE(VA), .VFP(VF), .VSYN(VSY), .VBP(VB),
                    .HS_POL(1'b0), .VS_POL(1'b0), .CLKDIV(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_pix_ce(a_pix_ce),
      .o_hs(a_hs), .o_vs(a_vs), .o_blank_n(a_blank_n), .o_sync_n(a_sync_n),
      .o_x(a_x), .o_y(a_y), .o_sol(a_sol), .o_sof(a_sof));

   vga_timing_gen #(.CW(11), .HACTIVE(HA), .HFP(HF), .HSYN(HSY), .HBP(HB),
                    .VACTIVE(VA), .VFP(VF), .VSYN(VSY), .VBP(VB),
                    .HS_POL(1'b1), .VS_POL(1'b1), .CLKDIV(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_pix_ce(b_pix_ce),
      .o_hs(b_hs), .o_vs(b_vs), .o_blank_n(b_blank_n), .o_sync_n(b_sync_n),
      .o_x(b_x), .o_y(b_y), .o_sol(b_sol), .o_sof(b_sof));

   assign act0 = {a_pix_ce, a_hs, a_vs, a_blank_n, a_sync_n, a_sol, a_sof, a_x, a_y};
   assign act1 = {b_pix_ce, b_hs, b_vs, b_blank_n, b_sync_n, b_sol, b_sof, b_x, b_y};

   // Expected outputs for raster position (h, v) written as plain range tests.
   function automatic logic [VW-1:0] model_vec(input int h, input int v, input bit pol, input bit ce);
      logic ha, va, hs_e, vs_e;
      logic [10:0] xe, ye;
      ha   = (h >= HSS_T) && (h < HSE_T);
      va   = (v >= VSS_T) && (v < VSE_T);
      xe   = ha ? 11'(h - HSS_T) : 11'd0;
      ye   = va ? 11'(v - VSS_T) : 11'd0;
      hs_e = (h < HSY) ? pol : ~pol;
      vs_e = (v < VSY) ? pol : ~pol;
      return {ce, hs_e, vs_e, ha && va, 1'b1, ce && (h == 0), ce && (h == 0) && (v == 0), xe, ye};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_div[k] = 0;
         m_h[k]   = 0;
         m_v[k]   = 0;
      end
   endtask

   task automatic model_step();
      logic [VW-1:0] e;
      int lim;
      bit ce;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         lim = (k == 0) ? 2 : 1;
         ce  = 1'b0;
         if (!rst_n) begin
            m_div[k] = 0; m_h[k] = 0; m_v[k] = 0;
         end else if (en) begin
            if (m_div[k] == lim - 1) begin
               ce = 1'b1;
               m_div[k] = 0;
               m_h[k]++;
               if (m_h[k] == HTOT_T) begin
                  m_h[k] = 0;
                  m_v[k]++;
                  if (m_v[k] == VTOT_T) m_v[k] = 0;
               end
            end else begin
               m_div[k]++;
            end
         end
         e = model_vec(m_h[k], m_v[k], (k == 1), ce);
         if (k == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   task automatic sb_check();
      logic [VW-1:0] e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         checks++;
         if (act0 !== e) $display("FAIL sb_a cycle %0d: got %h expected %h", cyc, act0, e);
         else passes++;
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         checks++;
         if (act1 !== e) $display("FAIL sb_b cycle %0d: got %h expected %h", cyc, act1, e);
         else passes++;
      end
   endtask

   always @(negedge rst_n) model_reset();
   always @(posedge clk) model_step();
   always @(negedge clk) sb_check();

   function automatic logic pick(input int sel);
      case (sel)
         S_APCE: return a_pix_ce;
         S_AHS:  return a_hs;
         S_AVS:  return a_vs;
         S_ABLK: return a_blank_n;
         S_ASOL: return a_sol;
         S_ASOF: return a_sof;
         S_BHS:  return b_hs;
         S_BVS:  return b_vs;
         S_BBLK: return b_blank_n;
         S_BSOL: return b_sol;
         S_BSOF: return b_sof;
         default: return 1'b0;
      endcase
   endfunction

   // Cycles from one high sample of sel to the next; -1 on timeout.
   task automatic period(input int sel, input int limit, output int n);
      int k;
      n = -1;
      k = 0;
      while (pick(sel) !== 1'b1 && k < limit) begin @(negedge clk); k++; end
      if (pick(sel) === 1'b1) begin
         k = 0;
         do begin @(negedge clk); k++; end while (pick(sel) !== 1'b1 && k < limit);
         if (pick(sel) === 1'b1) n = k;
      end
   endtask

   // Length in cycles of the next full run of sel at level lvl; -1 on timeout.
   task automatic width(input int sel, input logic lvl, input int limit, output int n);
      int k;
      n = -1;
      k = 0;
      while (pick(sel) === lvl && k < limit) begin @(negedge clk); k++; end
      while (pick(sel) !== lvl && k < limit) begin @(negedge clk); k++; end
      if (pick(sel) === lvl) begin
         k = 0;
         while (pick(sel) === lvl && k < limit) begin @(negedge clk); k++; end
         if (pick(sel) !== lvl) n = k;
      end
   endtask

   task automatic test_reset();
      int first_a, first_b;
      rst_n = 1'b1;
      en    = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (a_pix_ce !== 1'b0) $display("FAIL rst_pix_ce: got %b expected 0", a_pix_ce); else passes++;
      checks++; if (a_hs !== 1'b0) $display("FAIL rst_hs_a: got %b expected 0", a_hs); else passes++;
      checks++; if (a_vs !== 1'b0) $display("FAIL rst_vs_a: got %b expected 0", a_vs); else passes++;
      checks++; if (a_blank_n !== 1'b0) $display("FAIL rst_blank_n: got %b expected 0", a_blank_n); else passes++;
      checks++; if (a_sync_n !== 1'b1) $display("FAIL rst_sync_n: got %b expected 1", a_sync_n); else passes++;
      checks++; if (a_x !== 11'd0) $display("FAIL rst_x: got %0d expected 0", a_x); else passes++;
      checks++; if (a_y !== 11'd0) $display("FAIL rst_y: got %0d expected 0", a_y); else passes++;
      checks++; if (a_sol !== 1'b0) $display("FAIL rst_sol: got %b expected 0", a_sol); else passes++;
      checks++; if (a_sof !== 1'b0) $display("FAIL rst_sof: got %b expected 0", a_sof); else passes++;
      checks++; if (b_hs !== 1'b1) $display("FAIL rst_hs_b: got %b expected 1", b_hs); else passes++;
      checks++; if (b_vs !== 1'b1) $display("FAIL rst_vs_b: got %b expected 1", b_vs); else passes++;
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      first_a = -1;
      first_b = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (first_a < 0 && a_pix_ce === 1'b1) first_a = c;
         if (first_b < 0 && b_pix_ce === 1'b1) first_b = c;
      end
      checks++; if (first_a !== 2) $display("FAIL first_pix_ce_a: got %0d expected 2", first_a); else passes++;
      checks++; if (first_b !== 1) $display("FAIL first_pix_ce_b: got %0d expected 1", first_b); else passes++;
   endtask

   task automatic test_line_timing();
      int n;
      period(S_APCE, 20, n);
      checks++; if (n !== 2) $display("FAIL pix_ce_period_a: got %0d expected 2", n); else passes++;
      period(S_ASOL, 2000, n);
      checks++; if (n !== 2 * HTOT_T) $display("FAIL sol_period_a: got %0d expected %0d", n, 2 * HTOT_T); else passes++;
      width(S_AHS, 1'b0, 2000, n);
      checks++; if (n !== 2 * HSY) $display("FAIL hs_width_a: got %0d expected %0d", n, 2 * HSY); else passes++;
      width(S_ABLK, 1'b1, 2000, n);
      checks++; if (n !== 2 * HA) $display("FAIL blank_width_a: got %0d expected %0d", n, 2 * HA); else passes++;
      period(S_BSOL, 2000, n);
      checks++; if (n !== HTOT_T) $display("FAIL sol_period_b: got %0d expected %0d", n, HTOT_T); else passes++;
      width(S_BHS, 1'b1, 2000, n);
      checks++; if (n !== HSY) $display("FAIL hs_width_b: got %0d expected %0d", n, HSY); else passes++;
      width(S_BBLK, 1'b1, 2000, n);
      checks++; if (n !== HA) $display("FAIL blank_width_b: got %0d expected %0d", n, HA); else passes++;
   endtask

   task automatic test_frame_timing();
      int n;
      period(S_ASOF, 2000, n);
      checks++; if (n !== 2 * HTOT_T * VTOT_T) $display("FAIL sof_period_a: got %0d expected %0d", n, 2 * HTOT_T * VTOT_T); else passes++;
      width(S_AVS, 1'b0, 2000, n);
      checks++; if (n !== 2 * HTOT_T * VSY) $display("FAIL vs_width_a: got %0d expected %0d", n, 2 * HTOT_T * VSY); else passes++;
      period(S_BSOF, 2000, n);
      checks++; if (n !== HTOT_T * VTOT_T) $display("FAIL sof_period_b: got %0d expected %0d", n, HTOT_T * VTOT_T); else passes++;
      width(S_BVS, 1'b1, 2000, n);
      checks++; if (n !== HTOT_T * VSY) $display("FAIL vs_width_b: got %0d expected %0d", n, HTOT_T * VSY); else passes++;
   endtask

   task automatic test_x_sweep();
      int k, idx;
      k = 0;
      while (a_blank_n !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
      while (a_blank_n !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
      idx = 0;
      while (a_blank_n === 1'b1 && k < 2000) begin
         if (a_pix_ce === 1'b1) begin
            checks++;
            if (a_x !== 11'(idx)) $display("FAIL x_step: got %0d expected %0d", a_x, idx);
            else passes++;
            idx++;
         end
         @(negedge clk);
         k++;
      end
      checks++; if (idx !== HA) $display("FAIL x_count: got %0d expected %0d", idx, HA); else passes++;
   endtask

   task automatic test_freeze();
      logic [VW-1:0] held;
      int k, t_sof, len;
      held = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd10, 11'd3};
      k = 0;
      while (a_sof !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
      t_sof = cyc;
      @(negedge clk);
      while (!(a_pix_ce === 1'b1 && a_x === 11'd10 && a_y === 11'd3) && k < 2000) begin @(negedge clk); k++; end
      en = 1'b0;
      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         checks++;
         if (act0 !== held) $display("FAIL freeze_hold %0d: got %h expected %h", i, act0, held);
         else passes++;
      end
      en = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (a_pix_ce !== 1'b1 && k < 10);
      checks++; if (a_x !== 11'd11) $display("FAIL resume_x: got %0d expected 11", a_x); else passes++;
      k = 0;
      while (a_sof !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
      len = (a_sof === 1'b1) ? cyc - t_sof : -1;
      checks++;
      if (len !== 2 * HTOT_T * VTOT_T + 37) $display("FAIL freeze_frame_len: got %0d expected %0d", len, 2 * HTOT_T * VTOT_T + 37);
      else passes++;
   endtask

   task automatic test_reset_midframe();
      int k, sof_a, sof_b;
      k = 0;
      while (!(a_blank_n === 1'b1 && a_y === 11'd4) && k < 2000) begin @(negedge clk); k++; end
      checks++; if (a_y !== 11'd4) $display("FAIL mid_reach_y: got %0d expected 4", a_y); else passes++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_blank_n !== 1'b0) $display("FAIL mid_rst_blank_n: got %b expected 0", a_blank_n); else passes++;
      checks++; if (a_x !== 11'd0) $display("FAIL mid_rst_x: got %0d expected 0", a_x); else passes++;
      checks++; if (a_y !== 11'd0) $display("FAIL mid_rst_y: got %0d expected 0", a_y); else passes++;
      checks++; if (a_hs !== 1'b0) $display("FAIL mid_rst_hs_a: got %b expected 0", a_hs); else passes++;
      checks++; if (a_vs !== 1'b0) $display("FAIL mid_rst_vs_a: got %b expected 0", a_vs); else passes++;
      checks++; if (a_pix_ce !== 1'b0) $display("FAIL mid_rst_pix_ce: got %b expected 0", a_pix_ce); else passes++;
      checks++; if (b_hs !== 1'b1) $display("FAIL mid_rst_hs_b: got %b expected 1", b_hs); else passes++;
      checks++; if (b_vs !== 1'b1) $display("FAIL mid_rst_vs_b: got %b expected 1", b_vs); else passes++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sof_a = -1;
      sof_b = -1;
      for (int c = 1; c <= 700 && sof_a < 0; c++) begin
         @(negedge clk);
         if (sof_b < 0 && b_sof === 1'b1) sof_b = c;
         if (sof_a < 0 && a_sof === 1'b1) sof_a = c;
      end
      checks++; if (sof_a !== 2 * HTOT_T * VTOT_T) $display("FAIL first_sof_a: got %0d expected %0d", sof_a, 2 * HTOT_T * VTOT_T); else passes++;
      checks++; if (sof_b !== HTOT_T * VTOT_T) $display("FAIL first_sof_b: got %0d expected %0d", sof_b, HTOT_T * VTOT_T); else passes++;
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_x_sweep();
      test_freeze();
      test_reset_midframe();
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
